vga_sync_decoder: RTL and testbench

// - Receive-side counterpart of the VGA timing generator: consumes hout/vout/aout-style sync and active

---
 rtl/vga_pkg.sv | 16 +
 rtl/vga_edge_det.sv | 31 +++
 rtl/vga_sync_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: decoder FSM states and 640x480@60 timing constants.
// Also used by the matching timing generator.
package vga_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam int H_TOTAL  = 800;
  localparam int H_SYNC   = 96;
  localparam int H_ACTIVE = 640;
  localparam int V_TOTAL  = 525;

endpackage

// File: rtl/vga_edge_det.sv
// Registers one sync input, normalises polarity (1 = sync asserted)
// and flags leading/trailing transitions of the registered level.
module vga_edge_det #(
  parameter bit POL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic lvl_o,
  output logic lead_o,
  output logic trail_o
);

  logic lvl_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lvl_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      lvl_q  <= (sig_i == POL);
      prev_q <= lvl_q;
    end
  end

  assign lvl_o   = lvl_q;
  assign lead_o  = lvl_q & ~prev_q;
  assign trail_o = ~lvl_q & prev_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Measures incoming VGA line/frame geometry, locks onto a stable
// format and recovers per-pixel x/y coordinates.
module vga_sync_decoder #(
  parameter int CW          = 16,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          clkin,
  input  logic          rst_n,
  input  logic          hin,
  input  logic          vin,
  input  logic          ain,
  output logic [CW-1:0] htotal,
  output logic [CW-1:0] hsw,
  output logic [CW-1:0] hactive,
  output logic [CW-1:0] vtotal,
  output logic          locked,
  output logic [CW-1:0] xpos,
  output logic [CW-1:0] ypos,
  output logic          pix_valid,
  output logic          fstart
);

  import vga_pkg::*;

  localparam logic [CW-1:0] MAXV = '1;
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [7:0]    THR  = 8'(LOCK_FRAMES - 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == MAXV) ? v : v + ONE;
  endfunction

  logic h_lvl, h_lead, h_trail;
  logic v_lvl, v_lead, v_trail;
  logic v_unused;

  vga_edge_det #(.POL(SYNC_POL)) u_hdet (
    .clk_i   (clkin),
    .rst_ni  (rst_n),
    .sig_i   (hin),
    .lvl_o   (h_lvl),
    .lead_o  (h_lead),
    .trail_o (h_trail)
  );

  vga_edge_det #(.POL(SYNC_POL)) u_vdet (
    .clk_i   (clkin),
    .rst_ni  (rst_n),
    .sig_i   (vin),
    .lvl_o   (v_lvl),
    .lead_o  (v_lead),
    .trail_o (v_trail)
  );

  assign v_unused = v_lvl ^ v_trail;

  logic          a_q, act_q;
  logic [CW-1:0] line_q, line_d;
  logic [CW-1:0] hswc_q, hswc_d;
  logic [CW-1:0] hact_q, hact_d;
  logic [CW-1:0] vline_q, vline_d;
  logic [CW-1:0] htotal_q, htotal_d;
  logic [CW-1:0] hsw_q, hsw_d;
  logic [CW-1:0] hactive_q, hactive_d;
  logic [CW-1:0] vtotal_q, vtotal_d;
  logic [CW-1:0] xpos_q, xpos_d;
  logic [CW-1:0] ypos_q, ypos_d;
  logic          sat;

  always_comb begin
    line_d    = sat_inc(line_q);
    htotal_d  = htotal_q;
    hswc_d    = hswc_q;
    hsw_d     = hsw_q;
    hact_d    = hact_q;
    hactive_d = hactive_q;
    vline_d   = vline_q;
    vtotal_d  = vtotal_q;
    xpos_d    = xpos_q;
    ypos_d    = ypos_q;
    if (h_lead) begin
      line_d    = ONE;
      htotal_d  = line_q;
      hswc_d    = ONE;
      hact_d    = {{(CW-1){1'b0}}, a_q};
      hactive_d = hact_q;
      xpos_d    = '0;
      if (hact_q != '0) ypos_d = sat_inc(ypos_q);
    end else begin
      if (h_lvl) hswc_d = sat_inc(hswc_q);
      if (a_q)   hact_d = sat_inc(hact_q);
      if (act_q) xpos_d = sat_inc(xpos_q);
    end
    if (h_trail) hsw_d = hswc_q;
    // A coincident hsync edge opens the new frame as its first line
    if (v_lead) begin
      vtotal_d = vline_q;
      vline_d  = h_lead ? ONE : '0;
      ypos_d   = '0;
    end else if (h_lead) begin
      vline_d = sat_inc(vline_q);
    end
  end

  assign sat = (line_q == MAXV) | (hswc_q == MAXV) |
               (hact_q == MAXV) | (vline_q == MAXV);

  state_e          state_q, state_d;
  logic [4*CW-1:0] snap_q, snap_d, cur;
  logic            snap_vld_q, snap_vld_d;
  logic [7:0]      match_q, match_d;

  assign cur = {htotal_d, hsw_d, hactive_d, vtotal_d};

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    snap_vld_d = snap_vld_q;
    match_d    = match_q;
    unique case (state_q)
      SEARCH: begin
        if (v_lead) begin
          state_d    = MEASURE;
          snap_vld_d = 1'b0;
          match_d    = '0;
        end
      end
      MEASURE: begin
        if (v_lead) begin
          snap_d     = cur;
          snap_vld_d = 1'b1;
          if (snap_vld_q && (cur == snap_q)) begin
            match_d = match_q + 8'd1;
            if (match_d >= THR) state_d = LOCKED;
          end else begin
            match_d = '0;
          end
        end
      end
      LOCKED: begin
        if (h_lead && (htotal_d != snap_q[4*CW-1 -: CW]))
          state_d = SEARCH;
        if (v_lead && (vtotal_d != snap_q[CW-1:0]))
          state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
    if (sat) state_d = SEARCH;
  end

  logic locked_q, pix_valid_q, fstart_q;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= 1'b0;
      act_q       <= 1'b0;
      line_q      <= '0;
      hswc_q      <= '0;
      hact_q      <= '0;
      vline_q     <= '0;
      htotal_q    <= '0;
      hsw_q       <= '0;
      hactive_q   <= '0;
      vtotal_q    <= '0;
      xpos_q      <= '0;
      ypos_q      <= '0;
      state_q     <= SEARCH;
      snap_q      <= '0;
      snap_vld_q  <= 1'b0;
      match_q     <= '0;
      locked_q    <= 1'b0;
      pix_valid_q <= 1'b0;
      fstart_q    <= 1'b0;
    end else begin
      a_q         <= ain;
      act_q       <= a_q;
      line_q      <= line_d;
      hswc_q      <= hswc_d;
      hact_q      <= hact_d;
      vline_q     <= vline_d;
      htotal_q    <= htotal_d;
      hsw_q       <= hsw_d;
      hactive_q   <= hactive_d;
      vtotal_q    <= vtotal_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      state_q     <= state_d;
      snap_q      <= snap_d;
      snap_vld_q  <= snap_vld_d;
      match_q     <= match_d;
      locked_q    <= (state_d == LOCKED);
      pix_valid_q <= (state_d == LOCKED) & a_q;
      fstart_q    <= v_lead;
    end
  end

  assign htotal    = htotal_q;
  assign hsw       = hsw_q;
  assign hactive   = hactive_q;
  assign vtotal    = vtotal_q;
  assign locked    = locked_q;
  assign xpos      = xpos_q;
  assign ypos      = ypos_q;
  assign pix_valid = pix_valid_q;
  assign fstart    = fstart_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench: a 16-bit active-low instance for real formats and
// an 8-bit active-high instance for the toy/saturation cases.
module tb_vga_sync_decoder;

  import vga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_hin, a_vin, a_ain;
  logic [15:0] a_htotal, a_hsw, a_hactive, a_vtotal, a_xpos, a_ypos;
  logic        a_locked, a_pix_valid, a_fstart;

  logic        b_rst_n, b_hin, b_vin, b_ain;
  logic [7:0]  b_htotal, b_hsw, b_hactive, b_vtotal, b_xpos, b_ypos;
  logic        b_locked, b_pix_valid, b_fstart;

  vga_sync_decoder #(.CW(16), .SYNC_POL(1'b0), .LOCK_FRAMES(2)) dut_a (
    .clkin(clk), .rst_n(a_rst_n), .hin(a_hin), .vin(a_vin), .ain(a_ain),
    .htotal(a_htotal), .hsw(a_hsw), .hactive(a_hactive),
    .vtotal(a_vtotal), .locked(a_locked), .xpos(a_xpos), .ypos(a_ypos),
    .pix_valid(a_pix_valid), .fstart(a_fstart)
  );

  vga_sync_decoder #(.CW(8), .SYNC_POL(1'b1), .LOCK_FRAMES(2)) dut_b (
    .clkin(clk), .rst_n(b_rst_n), .hin(b_hin), .vin(b_vin), .ain(b_ain),
    .htotal(b_htotal), .hsw(b_hsw), .hactive(b_hactive),
    .vtotal(b_vtotal), .locked(b_locked), .xpos(b_xpos), .ypos(b_ypos),
    .pix_valid(b_pix_valid), .fstart(b_fstart)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  int f_htot, f_hsw, f_hst, f_hlen, f_lines, f_vsl, f_ast, f_alen;
  int f_drop = -1;
  int tgt = 0;

  task automatic set_fmt(input int ht, hs, hst, hl, ln, vs, ast, al);
    f_htot = ht; f_hsw = hs; f_hst = hst; f_hlen = hl;
    f_lines = ln; f_vsl = vs; f_ast = ast; f_alen = al;
    f_drop = -1;
  endtask

  function automatic int linelen(input int l);
    return (l == f_drop) ? f_htot - 1 : f_htot;
  endfunction

  task automatic step(input int l, input int h);
    logic hs, vs, ac;
    hs = (h < f_hsw);
    vs = (l < f_vsl);
    ac = (l >= f_ast) && (l < f_ast + f_alen) &&
         (h >= f_hst) && (h < f_hst + f_hlen);
    if (tgt == 0) begin
      a_hin = ~hs; a_vin = ~vs; a_ain = ac;
    end else begin
      b_hin = hs; b_vin = vs; b_ain = ac;
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input int l0, h0, l1, h1);
    int l, h;
    l = l0; h = h0;
    while (!(l == l1 && h == h1) && l <= f_lines) begin
      step(l, h);
      h++;
      if (h >= linelen(l)) begin
        h = 0;
        l++;
      end
    end
  endtask

  task automatic frame();
    run(0, 0, f_lines, 0);
  endtask

  task automatic idle_b(input int n);
    b_hin = 1'b0; b_vin = 1'b0; b_ain = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    a_hin = 1'b1; a_vin = 1'b1; a_ain = 1'b0;
    a_rst_n = 1'b1; #1; a_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 a_rst_n = 1'b1;
  endtask

  task automatic reset_b();
    b_hin = 1'b0; b_vin = 1'b0; b_ain = 1'b0;
    b_rst_n = 1'b1; #1; b_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 b_rst_n = 1'b1;
  endtask

  typedef struct {
    int htot, hsw, hst, hlen, lines, vsl, ast, alen;
    int e_htot, e_hsw, e_hact, e_vtot;
  } vec_t;

  vec_t tbl [3];

  logic mon_en = 1'b0;
  logic fs_prev = 1'b0;
  int   ex, ey, fcnt;

  always @(negedge clk) begin
    if (mon_en) begin
      if (b_pix_valid) begin
        chk("toy_xpos", b_xpos, ex);
        chk("toy_ypos", b_ypos, ey);
        ex++;
        if (ex == 10) begin
          ex = 0;
          ey++;
        end
      end
      if (b_fstart) begin
        fcnt++;
        chk("toy_fstart_single", fs_prev, 0);
      end
    end
    fs_prev = b_fstart;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{40, 4, 8, 24, 6, 1, 2, 3,   40, 4, 24, 6};
    tbl[1] = '{64, 10, 14, 48, 5, 2, 2, 2, 64, 10, 48, 5};
    tbl[2] = '{25, 1, 3, 20, 9, 3, 4, 4,   25, 1, 20, 9};

    a_hin = 1'b1; a_vin = 1'b1; a_ain = 1'b0;
    b_hin = 1'b0; b_vin = 1'b0; b_ain = 1'b0;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    #1;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_htotal", a_htotal, 0);
    chk("rst_hsw", a_hsw, 0);
    chk("rst_hactive", a_hactive, 0);
    chk("rst_vtotal", a_vtotal, 0);
    chk("rst_locked", a_locked, 0);
    chk("rst_xpos", a_xpos, 0);
    chk("rst_ypos", a_ypos, 0);
    chk("rst_pix_valid", a_pix_valid, 0);
    chk("rst_fstart", a_fstart, 0);
    chk("rst_b_locked", b_locked, 0);
    a_rst_n = 1'b1; b_rst_n = 1'b1;

    tgt = 0;
    for (int i = 0; i < 3; i++) begin
      reset_a();
      set_fmt(tbl[i].htot, tbl[i].hsw, tbl[i].hst, tbl[i].hlen,
              tbl[i].lines, tbl[i].vsl, tbl[i].ast, tbl[i].alen);
      frame();
      run(0, 0, tbl[i].ast + 1, tbl[i].hsw + 3);
      chk($sformatf("tbl%0d_htotal", i), a_htotal, tbl[i].e_htot);
      chk($sformatf("tbl%0d_hsw", i), a_hsw, tbl[i].e_hsw);
      chk($sformatf("tbl%0d_hactive", i), a_hactive, tbl[i].e_hact);
      chk($sformatf("tbl%0d_vtotal", i), a_vtotal, tbl[i].e_vtot);
      chk($sformatf("tbl%0d_unlocked", i), a_locked, 0);
    end

    reset_a();
    set_fmt(H_TOTAL, H_SYNC, 144, H_ACTIVE, 4, 1, 1, 2);
    frame();
    frame();
    chk("lock_before_f3", a_locked, 0);
    step(0, 0);
    chk("lock_f3_p0", a_locked, 0);
    chk("fstart_p0", a_fstart, 0);
    step(0, 1);
    chk("lock_f3_p1", a_locked, 1);
    chk("fstart_p1", a_fstart, 1);
    step(0, 2);
    chk("fstart_p2", a_fstart, 0);
    run(0, 3, 1, 151);
    chk("l1_pix_valid", a_pix_valid, 1);
    chk("l1_xpos", a_xpos, 5);
    chk("l1_ypos", a_ypos, 0);
    run(1, 151, 2, H_SYNC + 3);
    chk("main_htotal", a_htotal, 800);
    chk("main_hsw", a_hsw, 96);
    chk("main_hactive", a_hactive, 640);
    chk("main_vtotal", a_vtotal, 4);
    run(2, H_SYNC + 3, 2, 151);
    chk("l2_ypos", a_ypos, 1);
    chk("l2_xpos", a_xpos, 5);
    run(2, 151, 4, 0);

    f_drop = 1;
    run(0, 0, 2, 1);
    chk("drop_edge_still_locked", a_locked, 1);
    step(2, 1);
    chk("drop_unlocked", a_locked, 0);
    chk("drop_htotal", a_htotal, 799);
    f_drop = -1;
    run(2, 2, 4, 0);
    frame();
    frame();
    chk("drop_relock_early", a_locked, 0);
    step(0, 0);
    step(0, 1);
    chk("drop_relock", a_locked, 1);

    run(0, 2, 1, 200);
    chk("pre_rst_pix_valid", a_pix_valid, 1);
    a_rst_n = 1'b0;
    #1;
    chk("async_rst_locked", a_locked, 0);
    chk("async_rst_pix_valid", a_pix_valid, 0);
    chk("async_rst_htotal", a_htotal, 0);
    chk("async_rst_xpos", a_xpos, 0);
    chk("async_rst_vtotal", a_vtotal, 0);
    #1 a_rst_n = 1'b1;
    run(1, 200, 4, 0);
    chk("rst_partial_unlocked", a_locked, 0);
    frame();
    frame();
    chk("rst_relock_early", a_locked, 0);
    step(0, 0);
    step(0, 1);
    chk("rst_relock", a_locked, 1);

    reset_a();
    set_fmt(20, 3, 6, 10, V_TOTAL, 2, 10, 480);
    frame();
    step(0, 0);
    step(0, 1);
    chk("coinc_vtotal", a_vtotal, 525);
    chk("coinc_htotal", a_htotal, 20);

    tgt = 1;
    a_hin = 1'b1; a_vin = 1'b1; a_ain = 1'b0;
    reset_b();
    set_fmt(16, 2, 3, 10, 8, 1, 2, 4);
    frame();
    frame();
    frame();
    step(0, 0);
    step(0, 1);
    chk("toy_locked", b_locked, 1);
    run(0, 2, 8, 0);
    ex = 0; ey = 0; fcnt = 0;
    mon_en = 1'b1;
    frame();
    mon_en = 1'b0;
    chk("toy_rows", ey, 4);
    chk("toy_x_end", ex, 0);
    chk("toy_fstart_count", fcnt, 1);
    chk("toy_htotal", b_htotal, 16);
    chk("toy_hsw", b_hsw, 2);

    idle_b(100);
    chk("sat_pre_locked", b_locked, 1);
    idle_b(200);
    chk("sat_unlocked", b_locked, 0);
    run(0, 0, 0, 3);
    chk("sat_htotal", b_htotal, 255);
    chk("sat_still_unlocked", b_locked, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
